uart_rx_core: RTL and testbench



---
 rtl/uart_rx_core_if.sv | 13 +
 rtl/uart_rx_core.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - received-character valid/ready interface
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;

    modport master (output rx_data, rx_valid, parity_err, frame_err, input rx_ready);
    modport slave  (input rx_data, rx_valid, parity_err, frame_err, output rx_ready);
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampled UART receiver with 3-sample majority vote
// and a held valid/ready character output carrying parity and framing status.
module uart_rx_core #(
    parameter int CLK_HZ      = 30000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           uart_rx,
    uart_rx_core_if.master rx_if,
    output logic           overrun,
    output logic           busy
);
    localparam int   DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int   H   = OVERSAMPLE / 2;
    localparam int   DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int   SW  = $clog2(OVERSAMPLE);
    localparam int   BW  = $clog2(DATA_BITS + 1);
    localparam logic ODD = (PARITY == 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx_core: clock too slow for BAUD*OVERSAMPLE (DIV < 2)");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, fill_q;
    logic                   rx_s, rx_prev_q;
    logic [DW-1:0]          div_q;
    logic [SW-1:0]          samp_q;
    logic [BW-1:0]          bit_cnt_q;
    logic                   v0_q, v1_q;
    logic [DATA_BITS-1:0]   shreg_q, rx_data_q;
    logic                   par_err_q, frm_err_q, done_q;
    logic                   rx_valid_q, parity_err_q, frame_err_q, overrun_q;
    logic                   tick, bit_end, vote, maj, start_det, frame_done;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        tick       = (div_q == DW'(DIV - 1));
        bit_end    = tick && (samp_q == SW'(OVERSAMPLE - 1));
        vote       = tick && (samp_q == SW'(H + 1));
        maj        = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
        start_det  = 1'b0;
        frame_done = 1'b0;
        state_d    = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    start_det = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (vote && maj)  state_d = S_IDLE;
                else if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_cnt_q == BW'(DATA_BITS - 1))
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // leave on the last vote so an immediately following start edge is seen
                if (vote && bit_cnt_q == BW'(STOP_BITS - 1)) begin
                    state_d    = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q       <= '1;
            fill_q       <= '0;
            rx_prev_q    <= 1'b0;
            div_q        <= '0;
            samp_q       <= '0;
            bit_cnt_q    <= '0;
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            shreg_q      <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            // rx_prev only trusts rx_s once the chain holds real line samples, so a line
            // still low out of reset needs a genuine high-then-low before a start
            rx_prev_q <= rx_s & fill_q[SYNC_STAGES-1];

            if (start_det || tick) div_q <= '0;
            else                   div_q <= div_q + 1'b1;

            if (start_det)
                samp_q <= '0;
            else if (tick)
                samp_q <= (samp_q == SW'(OVERSAMPLE - 1)) ? '0 : samp_q + 1'b1;

            if (state_d != state_q) bit_cnt_q <= '0;
            else if (bit_end)       bit_cnt_q <= bit_cnt_q + 1'b1;

            if (tick && samp_q == SW'(H - 1)) v0_q <= rx_s;
            if (tick && samp_q == SW'(H))     v1_q <= rx_s;

            if (vote && state_q == S_DATA) shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};

            if (start_det)                       par_err_q <= 1'b0;
            else if (vote && state_q == S_PARITY) par_err_q <= maj ^ (^shreg_q) ^ ODD;

            if (start_det)                           frm_err_q <= 1'b0;
            else if (vote && state_q == S_STOP && !maj) frm_err_q <= 1'b1;

            done_q    <= frame_done;
            overrun_q <= 1'b0;
            if (done_q) begin
                if (!rx_valid_q || rx_if.rx_ready) begin
                    rx_data_q    <= shreg_q;
                    parity_err_q <= par_err_q;
                    frame_err_q  <= frm_err_q;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_if.rx_ready) begin
                rx_valid_q   <= 1'b0;
                parity_err_q <= 1'b0;
                frame_err_q  <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.rx_valid   = rx_valid_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.frame_err  = frame_err_q;
    assign overrun          = overrun_q;
    assign busy             = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core in three frame formats
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int CLK_HZ  = 1600000;
    localparam int BAUD    = 10000;
    localparam int OS      = 16;
    localparam int BIT     = 160;
    // sync + edge detect + 9 bits + ticks to the mid vote (sample 9) + load edge
    localparam int EXP_LAT = 2 + 1 + 9 * BIT + 10 * (OS / 2 + 2) + 1;

    typedef struct {
        int         id;
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] line = 3'b111;
    logic       ovr0, ovr1, ovr2, busy0, busy1, busy2;
    exp_t       sb[$];
    int         tests = 0, fails = 0;
    int         cyc = 0, start_cyc = 0, valid_cyc = 0, valid_hi0 = 0, ovr_cnt = 0, lat;

    uart_rx_core_if #(.DATA_BITS(8)) if0 ();
    uart_rx_core_if #(.DATA_BITS(8)) if1 ();
    uart_rx_core_if #(.DATA_BITS(7)) if2 ();

    uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .SYNC_STAGES(2),
                   .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut0 (.clk(clk), .reset_n(rst_n), .uart_rx(line[0]), .rx_if(if0), .overrun(ovr0), .busy(busy0));
    uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .SYNC_STAGES(2),
                   .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        dut1 (.clk(clk), .reset_n(rst_n), .uart_rx(line[1]), .rx_if(if1), .overrun(ovr1), .busy(busy1));
    uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .SYNC_STAGES(2),
                   .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
        dut2 (.clk(clk), .reset_n(rst_n), .uart_rx(line[2]), .rx_if(if2), .overrun(ovr2), .busy(busy2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input int id, input logic [8:0] data, input logic pe, input logic fe);
        exp_t e;
        e.id = id; e.data = data; e.pe = pe; e.fe = fe;
        sb.push_back(e);
    endtask

    task automatic accept(input int id, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame dut%0d: got 0x%0h expected none", id, d);
        end else begin
            e = sb.pop_front();
            check("frame_source", id, e.id);
            check("rx_data", d, e.data);
            check("parity_err", pe, e.pe);
            check("frame_err", fe, e.fe);
        end
    endtask

    // monitor: pops the scoreboard on every accepted character
    always @(negedge clk) begin
        if (if0.rx_valid) valid_hi0++;
        if (ovr0 || ovr1 || ovr2) ovr_cnt++;
        if (if0.rx_valid && if0.rx_ready) begin
            valid_cyc = cyc;
            accept(0, {1'b0, if0.rx_data}, if0.parity_err, if0.frame_err);
        end
        if (if1.rx_valid && if1.rx_ready) accept(1, {1'b0, if1.rx_data}, if1.parity_err, if1.frame_err);
        if (if2.rx_valid && if2.rx_ready) accept(2, {2'b0, if2.rx_data}, if2.parity_err, if2.frame_err);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // par < 0: no parity bit; g_at/g_len: low glitch at clock offsets from the start edge
    task automatic send(input int id, input logic [8:0] data, input int nbits, input int par,
                        input int nstop, input logic stop0, input int g_at, input int g_len);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
        if (par >= 0) bits.push_back(par[0]);
        for (int i = 0; i < nstop; i++) bits.push_back((i == 0) ? stop0 : 1'b1);
        for (int c = 0; c < bits.size() * BIT; c++) begin
            line[id] = (c >= g_at && c < g_at + g_len) ? 1'b0 : bits[c / BIT];
            if (c == 0) start_cyc = cyc;
            @(negedge clk);
        end
        line[id] = 1'b1;
    endtask

    task automatic check_quiet0(input string tag);
        check({tag, "_rx_valid"}, if0.rx_valid, 0);
        check({tag, "_rx_data"}, if0.rx_data, 0);
        check({tag, "_parity_err"}, if0.parity_err, 0);
        check({tag, "_frame_err"}, if0.frame_err, 0);
        check({tag, "_overrun"}, ovr0, 0);
        check({tag, "_busy"}, busy0, 0);
    endtask

    initial begin
        if0.rx_ready = 1'b1;
        if1.rx_ready = 1'b1;
        if2.rx_ready = 1'b1;
        idle(5);
        check_quiet0("reset");
        rst_n = 1'b1;
        idle(20);

        // 8N1 0xA5, latency and single-cycle valid
        valid_hi0 = 0;
        valid_cyc = -100000;
        expect_frame(0, 9'h0A5, 1'b0, 1'b0);
        send(0, 9'h0A5, 8, -1, 1, 1'b1, -1, 0);
        lat = valid_cyc - start_cyc;
        tests++;
        if (lat < EXP_LAT - 12 || lat > EXP_LAT + 12) begin
            fails++;
            $display("FAIL t1_latency: got %0d cycles expected %0d +/-12", lat, EXP_LAT);
        end
        idle(100);
        check("t1_valid_cycles", valid_hi0, 1);
        check("t1_busy", busy0, 0);
        check("t1_sb_empty", sb.size(), 0);

        // even parity: wrong then right parity bit
        expect_frame(1, 9'h037, 1'b1, 1'b0);
        send(1, 9'h037, 8, 0, 1, 1'b1, -1, 0);
        idle(160);
        expect_frame(1, 9'h037, 1'b0, 1'b0);
        send(1, 9'h037, 8, 1, 1, 1'b1, -1, 0);
        idle(100);
        check("t2_sb_empty", sb.size(), 0);

        // bad stop bit, then a clean frame
        expect_frame(0, 9'h05A, 1'b0, 1'b1);
        send(0, 9'h05A, 8, -1, 1, 1'b0, -1, 0);
        idle(160);
        expect_frame(0, 9'h001, 1'b0, 1'b0);
        send(0, 9'h001, 8, -1, 1, 1'b1, -1, 0);
        idle(100);
        check("t3_sb_empty", sb.size(), 0);

        // false start from a 40-clk idle pulse
        valid_hi0 = 0;
        line[0] = 1'b0;
        idle(20);
        check("t4_busy_on_pulse", busy0, 1);
        idle(20);
        line[0] = 1'b1;
        idle(200);
        check("t4_busy_after_pulse", busy0, 0);
        check("t4_no_valid", valid_hi0, 0);
        // glitch covering only the middle sample of data bit 3
        expect_frame(0, 9'h0FF, 1'b0, 1'b0);
        send(0, 9'h0FF, 8, -1, 1, 1'b1, 4 * BIT + 85, 10);
        idle(100);
        check("t4_sb_empty", sb.size(), 0);

        // overrun: consumer stalled across two back-to-back frames
        if0.rx_ready = 1'b0;
        ovr_cnt = 0;
        expect_frame(0, 9'h011, 1'b0, 1'b0);
        send(0, 9'h011, 8, -1, 1, 1'b1, -1, 0);
        send(0, 9'h022, 8, -1, 1, 1'b1, -1, 0);
        idle(50);
        check("t5_overrun_pulses", ovr_cnt, 1);
        check("t5_held_valid", if0.rx_valid, 1);
        check("t5_held_data", if0.rx_data, 8'h11);
        if0.rx_ready = 1'b1;
        idle(5);
        check("t5_valid_cleared", if0.rx_valid, 0);
        idle(200);
        check("t5_sb_empty", sb.size(), 0);
        check("t5_overrun_total", ovr_cnt, 1);

        // line break: one frame with frame error and zero data, no repeats
        expect_frame(0, 9'h000, 1'b0, 1'b1);
        line[0] = 1'b0;
        idle(12 * BIT);
        line[0] = 1'b1;
        idle(300);
        check("brk_sb_empty", sb.size(), 0);

        // reset during data bit 4 of 0xC3; line stays low after release
        fork
            send(0, 9'h0C3, 8, -1, 1, 1'b1, -1, 0);
        join_none
        idle(5 * BIT + 40);
        rst_n = 1'b0;
        idle(3);
        check_quiet0("in_reset");
        idle(17);
        rst_n = 1'b1;
        idle(5);
        check_quiet0("post_reset");
        wait fork;
        idle(1000);
        check("t6_no_spurious", sb.size(), 0);
        expect_frame(0, 9'h03C, 1'b0, 1'b0);
        send(0, 9'h03C, 8, -1, 1, 1'b1, -1, 0);
        idle(100);
        check("t6_sb_empty", sb.size(), 0);

        // 7 data bits, odd parity, two stop bits
        expect_frame(2, 9'h055, 1'b0, 1'b0);
        send(2, 9'h055, 7, 1, 2, 1'b1, -1, 0);
        idle(100);
        check("t7_sb_empty", sb.size(), 0);
        check("t7_busy", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
